line_block_memory: RTL and testbench

- Parametrised line-granular backing memory serving the data cache on a miss or writeback.
- Moves one cache line per access as a sequence of beats of BEAT_BYTES each.
- A programmable initial latency runs before the first beat.
- Uses the same read/write/busywait handshake as the existing dcache memory port, and adds clean per-access sequencing, abort handling and read/write conflict detection.

---
 rtl/line_block_memory_if.sv | 25 ++
 rtl/line_block_memory.sv | 136 +++++++++++++
 tb/tb_line_block_memory.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_block_memory_if.sv
// Request/response bundle between the data cache and the line-block memory.
// The master drives a line read or write; the slave reports busywait,
// the read line and a read/write conflict pulse.
interface line_block_memory_if #(
    parameter int ADDR_W     = 28,
    parameter int LINE_BYTES = 16
);
    logic                    read;
    logic                    write;
    logic [ADDR_W-1:0]       address;
    logic [LINE_BYTES*8-1:0] writedata;
    logic [LINE_BYTES*8-1:0] readdata;
    logic                    busywait;
    logic                    conflict;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait, conflict
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait, conflict
    );
endinterface

// File: rtl/line_block_memory.sv
// Line-granular backing memory for the data cache. Each access moves one
// line as BEATS beats of BEAT_BYTES, after an optional INIT_LATENCY wait.
// Requests use the read/write/busywait handshake; busywait drops for the
// single DONE cycle. Read and write together in IDLE raise a conflict pulse.
// Optional feature: define LINE_MEM_STATS_EN to add read_count/write_count.
module line_block_memory #(
    parameter int LINE_BYTES   = 16,
    parameter int BEAT_BYTES   = 1,
    parameter int MEM_BYTES    = 1024,
    parameter int INIT_LATENCY = 0,
    parameter int ADDR_W       = 28
) (
    input  logic               clock,
    input  logic               reset,
    line_block_memory_if.slave bus
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]        read_count,
    output logic [31:0]        write_count
`endif
);

    localparam int BEATS     = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_BITS = BEAT_BYTES * 8;
    localparam int NUM_LINES = MEM_BYTES / LINE_BYTES;
    localparam int MEM_WORDS = MEM_BYTES / BEAT_BYTES;
    localparam int LINE_W    = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [7:0] LAT_LAST = 8'((INIT_LATENCY > 0) ? INIT_LATENCY - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t                  state_q, state_d;
    logic [LINE_W-1:0]       line_q;
    logic                    is_write_q;
    logic [LINE_BYTES*8-1:0] wdata_q;
    logic [LINE_BYTES*8-1:0] readdata_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [7:0]              lat_q;
    logic                    conflict_q;
    logic [BEAT_BITS-1:0]    mem [MEM_WORDS];

    logic              req;
    logic              start;
    logic              last_beat;
    logic              lat_done;
    logic              beat_fire;
    logic [WORD_W-1:0] word_idx;

    assign req       = bus.read | bus.write;
    assign start     = (state_q == IDLE) && (bus.read ^ bus.write);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign lat_done  = (lat_q == LAT_LAST);
    assign beat_fire = (state_q == XFER) && req;
    assign word_idx  = WORD_W'(line_q * BEATS + beat_q);

    assign bus.busywait = req && (state_q != DONE);
    assign bus.readdata = readdata_q;
    assign bus.conflict = conflict_q;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; dropping both requests mid-access aborts to IDLE.
    // NOTE: state_d is given its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (INIT_LATENCY > 0) ? WAIT : XFER;
            WAIT: begin
                if (!req)          state_d = IDLE;
                else if (lat_done) state_d = XFER;
            end
            XFER: begin
                if (!req)           state_d = IDLE;
                else if (last_beat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching, counters, read beats and the conflict pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_q     <= '0;
            is_write_q <= 1'b0;
            wdata_q    <= '0;
            readdata_q <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= (state_q == IDLE) && bus.read && bus.write;
            if (state_d == IDLE) begin
                beat_q <= '0;
                lat_q  <= '0;
            end else begin
                if (state_q == WAIT && req) lat_q  <= lat_q + 8'd1;
                if (beat_fire)              beat_q <= beat_q + 1'b1;
            end
            if (start) begin
                line_q     <= LINE_W'(bus.address % ADDR_W'(NUM_LINES));
                is_write_q <= bus.write;
                wdata_q    <= bus.writedata;
            end
            if (beat_fire && !is_write_q)
                readdata_q[beat_q*BEAT_BITS +: BEAT_BITS] <= mem[word_idx];
        end
    end

    // Write beats into storage.
    // NOTE: storage deliberately has no reset; its contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (beat_fire && is_write_q)
            mem[word_idx] <= wdata_q[beat_q*BEAT_BITS +: BEAT_BITS];
    end

`ifdef LINE_MEM_STATS_EN
    // Count completed accesses on entry to DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (state_q == XFER && state_d == DONE) begin
            if (is_write_q) write_count <= write_count + 32'd1;
            else            read_count  <= read_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_block_memory.sv
// Directed bench for line_block_memory: a default instance (16 x 1-byte
// beats, no latency) and a wide instance (4 x 4-byte beats, latency 3).
module tb_line_block_memory;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    line_block_memory_if #(.ADDR_W(28), .LINE_BYTES(16)) a ();
    line_block_memory_if #(.ADDR_W(28), .LINE_BYTES(16)) b ();

    line_block_memory dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (a.slave)
    );

    line_block_memory #(.BEAT_BYTES(4), .INIT_LATENCY(3)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (b.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Line whose byte i equals base + i.
    function automatic logic [127:0] pat(input logic [7:0] base);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    // Line 3 after the aborted write: bytes 0..4 new (0x50+i), 5..15 old (i).
    function automatic logic [127:0] abort_line();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = (i < 5) ? 8'(8'h50 + i) : 8'(i);
        return r;
    endfunction

    // One complete access on instance a; returns the busywait-high cycle
    // count and leaves the bench in the DONE cycle with requests dropped.
    task automatic run_access(input logic wr, input logic [27:0] addr, input logic [127:0] wd,
                              input bit scramble, output int busy, output bit conf_seen);
        @(negedge clock);
        a.read = !wr; a.write = wr; a.address = addr; a.writedata = wd;
        busy = 0; conf_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            conf_seen = conf_seen | a.conflict;
            if (!a.busywait) break;
            busy++;
            @(negedge clock);
            if (scramble && i == 0) begin
                a.address   = addr ^ 28'h15;
                a.writedata = ~wd;
            end
        end
        a.read = 1'b0; a.write = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        total_cnt++;
        if (a.readdata !== 128'h0) $display("FAIL reset_readdata: got %h expected 0", a.readdata);
        else pass_cnt++;
        total_cnt++;
        if (a.busywait !== 1'b0 || a.conflict !== 1'b0)
            $display("FAIL reset_outputs: busywait=%b conflict=%b expected 0 0", a.busywait, a.conflict);
        else pass_cnt++;
        total_cnt++;
        if (b.readdata !== 128'h0) $display("FAIL reset_readdata_b: got %h expected 0", b.readdata);
        else pass_cnt++;
        a.read = 1'b1; #1;
        total_cnt++;
        if (a.busywait !== 1'b1) $display("FAIL reset_busy_req: got %b expected 1", a.busywait);
        else pass_cnt++;
        a.read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_wide_latency;
        int n;
        logic [127:0] exp;
        logic [127:0] line = pat(8'hA0);
        @(negedge clock);
        b.write = 1'b1; b.address = 28'd5; b.writedata = line;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!b.busywait) break;
            n++;
            @(negedge clock);
        end
        b.write = 1'b0;
        total_cnt++;
        if (n !== 8) $display("FAIL wide_write_busy: got %0d cycles expected 8", n);
        else pass_cnt++;
        @(negedge clock);
        b.read = 1'b1; b.address = 28'd5;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            // Cycle n+1 of the access: beats 0..(n+1-6) have been loaded.
            exp = '0;
            for (int k = 0; k < 4; k++)
                if (k < n + 1 - 5) exp[k*32 +: 32] = line[k*32 +: 32];
            total_cnt++;
            if (b.readdata !== exp)
                $display("FAIL wide_beat_order cycle %0d: got %h expected %h", n + 1, b.readdata, exp);
            else pass_cnt++;
            if (!b.busywait) break;
            n++;
            @(negedge clock);
        end
        b.read = 1'b0;
        total_cnt++;
        if (n !== 8) $display("FAIL wide_read_busy: got %0d cycles expected 8", n);
        else pass_cnt++;
    endtask

    task automatic test_write_read;
        int n;
        bit c;
        run_access(1'b1, 28'h3, pat(8'h00), 1'b0, n, c);
        total_cnt++;
        if (n !== 17 || c !== 1'b0) $display("FAIL write_busy: got %0d cycles conflict=%b expected 17 0", n, c);
        else pass_cnt++;
        run_access(1'b0, 28'h3, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (n !== 17 || c !== 1'b0) $display("FAIL read_busy: got %0d cycles conflict=%b expected 17 0", n, c);
        else pass_cnt++;
        total_cnt++;
        if (a.readdata !== pat(8'h00)) $display("FAIL read_data: got %h expected %h", a.readdata, pat(8'h00));
        else pass_cnt++;
    endtask

    task automatic test_alias;
        int n;
        bit c;
        run_access(1'b1, 28'h40, pat(8'h80), 1'b0, n, c);
        run_access(1'b0, 28'h0, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (a.readdata !== pat(8'h80)) $display("FAIL alias_line0: got %h expected %h", a.readdata, pat(8'h80));
        else pass_cnt++;
        run_access(1'b0, 28'h43, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (a.readdata !== pat(8'h00)) $display("FAIL alias_line3: got %h expected %h", a.readdata, pat(8'h00));
        else pass_cnt++;
    endtask

    task automatic test_latch;
        int n;
        bit c;
        run_access(1'b1, 28'h7, pat(8'h30), 1'b1, n, c);
        total_cnt++;
        if (n !== 17) $display("FAIL latch_busy: got %0d cycles expected 17", n);
        else pass_cnt++;
        run_access(1'b0, 28'h7, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (a.readdata !== pat(8'h30)) $display("FAIL latch_data: got %h expected %h", a.readdata, pat(8'h30));
        else pass_cnt++;
    endtask

    task automatic test_conflict;
        int n;
        bit c;
        @(negedge clock);
        a.read = 1'b1; a.write = 1'b1; a.address = 28'h3; a.writedata = '1;
        #1;
        total_cnt++;
        if (a.busywait !== 1'b1 || a.conflict !== 1'b0)
            $display("FAIL conflict_pre: busywait=%b conflict=%b expected 1 0", a.busywait, a.conflict);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (a.conflict !== 1'b1 || a.busywait !== 1'b1)
            $display("FAIL conflict_pulse: conflict=%b busywait=%b expected 1 1", a.conflict, a.busywait);
        else pass_cnt++;
        a.read = 1'b0; a.write = 1'b0;
        #1;
        total_cnt++;
        if (a.busywait !== 1'b0) $display("FAIL conflict_drop_busy: got %b expected 0", a.busywait);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (a.conflict !== 1'b0) $display("FAIL conflict_width: got %b expected 0", a.conflict);
        else pass_cnt++;
        run_access(1'b0, 28'h3, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (n !== 17 || a.readdata !== pat(8'h00))
            $display("FAIL conflict_mem: got %0d cycles %h expected 17 %h", n, a.readdata, pat(8'h00));
        else pass_cnt++;
    endtask

    task automatic test_abort;
        int n;
        bit c;
        @(negedge clock);
        a.write = 1'b1; a.address = 28'h3; a.writedata = pat(8'h50);
        repeat (6) @(posedge clock);
        @(negedge clock);
        a.write = 1'b0;
        run_access(1'b0, 28'h3, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (n !== 17) $display("FAIL abort_restart_busy: got %0d cycles expected 17", n);
        else pass_cnt++;
        total_cnt++;
        if (a.readdata !== abort_line()) $display("FAIL abort_data: got %h expected %h", a.readdata, abort_line());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int n;
        bit c;
        @(negedge clock);
        a.read = 1'b1; a.address = 28'h3;
        repeat (8) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (a.readdata !== 128'h0 || a.busywait !== 1'b1)
            $display("FAIL reset_mid: readdata=%h busywait=%b expected 0 1", a.readdata, a.busywait);
        else pass_cnt++;
        a.read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        run_access(1'b0, 28'h3, 128'h0, 1'b0, n, c);
        total_cnt++;
        if (n !== 17 || a.readdata !== abort_line())
            $display("FAIL reset_mid_reread: got %0d cycles %h expected 17 %h", n, a.readdata, abort_line());
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int n1;
        int n2;
        @(negedge clock);
        a.read = 1'b1; a.address = 28'h40;
        n1 = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!a.busywait) break;
            n1++;
            @(negedge clock);
        end
        // Request stays high through DONE; a fresh access must follow.
        @(negedge clock);
        n2 = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!a.busywait) break;
            n2++;
            @(negedge clock);
        end
        a.read = 1'b0;
        total_cnt++;
        if (n1 !== 17 || n2 !== 17) $display("FAIL b2b_busy: got %0d/%0d cycles expected 17/17", n1, n2);
        else pass_cnt++;
        total_cnt++;
        if (a.readdata !== pat(8'h80)) $display("FAIL b2b_data: got %h expected %h", a.readdata, pat(8'h80));
        else pass_cnt++;
    endtask

    initial begin
        a.read = 1'b0; a.write = 1'b0; a.address = '0; a.writedata = '0;
        b.read = 1'b0; b.write = 1'b0; b.address = '0; b.writedata = '0;
        test_reset;
        test_wide_latency;
        test_write_read;
        test_alias;
        test_latch;
        test_conflict;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
